rocket_boot_ctrl: RTL and testbench

ROCKET_BOOT_CTRL -- requirements
Module: rocket_boot_ctrl

---
 rtl/rocket_boot_ctrl.sv | 157 +++++++++++++++
 tb/tb_rocket_boot_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rocket_boot_ctrl.sv
// rocket_boot_ctrl: sequences clock lock, memory preload and core reset release
// for a rocket core. It also handles halt, software reboot, lock loss and boot
// timeout. Every output is a flop, so nothing combinational reaches the pins.
module rocket_boot_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 16,   // 1..255
  parameter int unsigned TIMEOUT_CYCLES = 1024  // 2..65535
) (
  input  logic       clock,
  input  logic       reset,          // asynchronous, active-low
  input  logic       pll_locked,
  input  logic       mem_init_done,
  input  logic       core_halt,
  input  logic       sw_reset_req,
  output logic       core_reset,
  output logic       mem_ok,
  output logic [2:0] boot_state,
  output logic       boot_done,
  output logic       boot_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_WAIT_MEM  = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4,
    S_HALTED    = 3'd5,
    S_ERROR     = 3'd6,
    S_UNUSED    = 3'd7
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  HOLD_LOAD    = 8'(HOLD_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic        sync_ff1;
  logic        rst_sync;
  logic        idle_go;
  logic [15:0] timeout_cnt;
  logic [7:0]  hold_cnt;
  logic        timeout_hit;
  logic        core_reset_d;
  logic        mem_ok_d;
  logic        boot_done_d;
  logic        boot_err_d;

  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
  assign boot_state  = state;

  // Reset release synchroniser. idle_go trails the synchronised release by one
  // more edge, so IDLE is left on the second edge after rst_sync rises.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_ff1 <= 1'b0;
      rst_sync <= 1'b0;
      idle_go  <= 1'b0;
    end else begin
      sync_ff1 <= 1'b1;
      rst_sync <= sync_ff1;
      idle_go  <= rst_sync;
    end
  end

  // State register. The raw reset clears it, so assertion acts at once.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic. Lock loss outranks everything once the core is released.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      S_IDLE:      if (idle_go) next_state = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (pll_locked)       next_state = S_WAIT_MEM;
        else if (timeout_hit) next_state = S_ERROR;
      end
      S_WAIT_MEM: begin
        if (!pll_locked)        next_state = S_WAIT_LOCK;
        else if (mem_init_done) next_state = S_HOLD;
        else if (timeout_hit)   next_state = S_ERROR;
      end
      S_HOLD: begin
        if (!pll_locked)         next_state = S_WAIT_LOCK;
        else if (hold_cnt == '0) next_state = S_RUN;
      end
      S_RUN: begin
        if (!pll_locked)       next_state = S_WAIT_LOCK;
        else if (sw_reset_req) next_state = S_HOLD;   // reboot beats halt
        else if (core_halt)    next_state = S_HALTED;
      end
      S_HALTED: begin
        if (!pll_locked)       next_state = S_WAIT_LOCK;
        else if (sw_reset_req) next_state = S_HOLD;
      end
      S_ERROR:  next_state = S_ERROR;
      S_UNUSED: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Timeout counter: cleared on entry to either wait state, counts while staying.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_cnt <= '0;
    end else if ((next_state == S_WAIT_LOCK || next_state == S_WAIT_MEM) &&
                 (next_state != state)) begin
      timeout_cnt <= '0;
    end else if ((state == S_WAIT_LOCK || state == S_WAIT_MEM) &&
                 (next_state == state)) begin
      timeout_cnt <= timeout_cnt + 16'd1;
    end
  end

  // Hold counter: loads on every entry to HOLD and counts down to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (next_state == S_HOLD && state != S_HOLD) begin
      hold_cnt <= HOLD_LOAD;
    end else if (state == S_HOLD && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  // Output decode from the next state. The registered outputs then line up
  // with boot_state on the same edge.
  always_comb begin
    core_reset_d = !(next_state == S_RUN || next_state == S_HALTED);
    mem_ok_d     = (next_state == S_HOLD) || (next_state == S_RUN) ||
                   (next_state == S_HALTED);
    boot_done_d  = (next_state == S_RUN);
    boot_err_d   = boot_err || (next_state == S_ERROR);
  end

  // Output registers. Reset values hold the core in reset with memory invalid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      core_reset <= 1'b1;
      mem_ok     <= 1'b0;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      core_reset <= core_reset_d;
      mem_ok     <= mem_ok_d;
      boot_done  <= boot_done_d;
      boot_err   <= boot_err_d;
    end
  end

endmodule

// File: tb/tb_rocket_boot_ctrl.sv
// Directed testbench for rocket_boot_ctrl with HOLD_CYCLES=16, TIMEOUT_CYCLES=8.
module tb_rocket_boot_ctrl;

  localparam int HOLD = 16;
  localparam int TMO  = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       mem_init_done;
  logic       core_halt;
  logic       sw_reset_req;
  logic       core_reset;
  logic       mem_ok;
  logic [2:0] boot_state;
  logic       boot_done;
  logic       boot_err;

  int n_cmp = 0;
  int n_bad = 0;

  rocket_boot_ctrl #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .mem_init_done (mem_init_done),
    .core_halt     (core_halt),
    .sw_reset_req  (sw_reset_req),
    .core_reset    (core_reset),
    .mem_ok        (mem_ok),
    .boot_state    (boot_state),
    .boot_done     (boot_done),
    .boot_err      (boot_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold reset for two edges, check reset values, then release between edges.
  task automatic reset_cycle();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #4;
    check("rst_state", boot_state, 3'd0);
    check("rst_core_reset", 3'(core_reset), 3'd1);
    check("rst_mem_ok", 3'(mem_ok), 3'd0);
    check("rst_boot_done", 3'(boot_done), 3'd0);
    check("rst_boot_err", 3'(boot_err), 3'd0);
    reset = 1'b1;
  endtask

  // From the first HOLD sample: expect exactly HOLD cycles in reset, then RUN.
  task automatic expect_hold_then_run(input string tag);
    for (int i = 0; i < HOLD; i++) begin
      check({tag, "_hold_state"}, boot_state, 3'd3);
      check({tag, "_hold_core_reset"}, 3'(core_reset), 3'd1);
      check({tag, "_hold_mem_ok"}, 3'(mem_ok), 3'd1);
      step(1);
    end
    check({tag, "_run_state"}, boot_state, 3'd4);
    check({tag, "_run_core_reset"}, 3'(core_reset), 3'd0);
    check({tag, "_run_boot_done"}, 3'(boot_done), 3'd1);
    check({tag, "_run_mem_ok"}, 3'(mem_ok), 3'd1);
  endtask

  initial begin
    reset         = 1'b0;
    pll_locked    = 1'b1;
    mem_init_done = 1'b1;
    core_halt     = 1'b0;
    sw_reset_req  = 1'b0;

    // Nominal boot: IDLE for three edges after release, then the sequence.
    reset_cycle();
    step(3);
    check("nom_idle", boot_state, 3'd0);
    step(1);
    check("nom_wait_lock", boot_state, 3'd1);
    check("nom_wl_core_reset", 3'(core_reset), 3'd1);
    check("nom_wl_mem_ok", 3'(mem_ok), 3'd0);
    step(1);
    check("nom_wait_mem", boot_state, 3'd2);
    step(1);
    expect_hold_then_run("nom");

    // Halt, stay halted, then a one-cycle software reboot.
    core_halt = 1'b1;
    step(1);
    core_halt = 1'b0;
    check("halt_state", boot_state, 3'd5);
    check("halt_core_reset", 3'(core_reset), 3'd0);
    check("halt_boot_done", 3'(boot_done), 3'd0);
    step(2);
    check("halt_stays", boot_state, 3'd5);
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    expect_hold_then_run("reboot");

    // Halt and reboot together in RUN: reboot wins.
    core_halt    = 1'b1;
    sw_reset_req = 1'b1;
    step(1);
    core_halt    = 1'b0;
    sw_reset_req = 1'b0;
    check("simul_state", boot_state, 3'd3);
    expect_hold_then_run("simul");

    // One-cycle lock loss in RUN forces a full re-boot.
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    check("lost_state", boot_state, 3'd1);
    check("lost_core_reset", 3'(core_reset), 3'd1);
    check("lost_mem_ok", 3'(mem_ok), 3'd0);
    check("lost_boot_done", 3'(boot_done), 3'd0);
    step(1);
    check("lost_wait_mem", boot_state, 3'd2);
    step(1);
    expect_hold_then_run("relock");

    // Asynchronous reset in the middle of HOLD, between clock edges.
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    step(3);
    check("async_pre_state", boot_state, 3'd3);
    #3;
    reset = 1'b0;
    #1;
    check("async_state", boot_state, 3'd0);
    check("async_core_reset", 3'(core_reset), 3'd1);
    check("async_mem_ok", 3'(mem_ok), 3'd0);

    // Memory never completes: timeout from WAIT_MEM.
    mem_init_done = 1'b0;
    reset_cycle();
    step(5);
    for (int i = 0; i < TMO; i++) begin
      check("memto_wait_mem", boot_state, 3'd2);
      check("memto_err_low", 3'(boot_err), 3'd0);
      step(1);
    end
    check("memto_error", boot_state, 3'd6);
    check("memto_boot_err", 3'(boot_err), 3'd1);

    // Reset from ERROR acts immediately; then the lock never comes.
    #3;
    reset = 1'b0;
    #1;
    check("err_async_state", boot_state, 3'd0);
    check("err_async_boot_err", 3'(boot_err), 3'd0);
    pll_locked = 1'b0;
    reset_cycle();
    step(4);
    for (int i = 0; i < TMO; i++) begin
      check("lockto_wait_lock", boot_state, 3'd1);
      step(1);
    end
    check("lockto_error", boot_state, 3'd6);
    check("lockto_boot_err", 3'(boot_err), 3'd1);
    check("lockto_core_reset", 3'(core_reset), 3'd1);
    check("lockto_mem_ok", 3'(mem_ok), 3'd0);

    // ERROR is terminal: good inputs and a reboot request change nothing.
    pll_locked    = 1'b1;
    mem_init_done = 1'b1;
    sw_reset_req  = 1'b1;
    step(1);
    sw_reset_req  = 1'b0;
    step(4);
    check("err_terminal", boot_state, 3'd6);
    check("err_sticky", 3'(boot_err), 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
